mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one multiplier_8_8 datapath between NUM_REQ requesters. It accepts one operand pair at a time, holds the operands stable on the multiplier inputs, and pulses the multiplier start. It then waits for done, or for a timeout, and returns the 16-bit product to the granted requester. It sits between requesting blocks and the multiplier top.

---
 rtl/mult_arb_pkg.sv | 28 ++
 rtl/rr_picker.sv | 39 +++
 rtl/mult_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// -----------------------------------------------------------------------------
// mult_arb_pkg
// Shared types and constants for the multiplier arbiter slice.
//   state_t         : sequencer states (IDLE=0, ISSUE=1, WAIT=2, RESP=3)
//   OPW / PRODW     : operand and product widths of the shared multiplier
//   DEFAULT_TIMEOUT : default WAIT-cycle budget before an error response
//   zero_operand()  : true when either operand is zero (used by the optional
//                     zero bypass, MULT_ARB_ZERO_BYPASS_EN)
// -----------------------------------------------------------------------------
package mult_arb_pkg;

    localparam int unsigned OPW             = 8;
    localparam int unsigned PRODW           = 16;
    localparam int unsigned DEFAULT_TIMEOUT = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    function automatic logic zero_operand(input logic [OPW-1:0] a,
                                          input logic [OPW-1:0] b);
        return (a == '0) || (b == '0);
    endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin selector: the winner is the first asserted
// request found searching upward from ptr, wrapping modulo N.
// Ports:
//   req_valid  in  N    request vector
//   ptr        in  IDW  index with highest priority this cycle
//   winner_oh  out N    one-hot winner (all zero when nothing is valid)
//   winner_idx out IDW  binary winner index (0 when nothing is valid)
//   any_valid  out 1    at least one request is valid
// -----------------------------------------------------------------------------
module rr_picker #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   req_valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   winner_oh,
    output logic [IDW-1:0] winner_idx,
    output logic           any_valid
);

    always_comb begin
        logic [IDW-1:0] idx;
        winner_oh  = '0;
        winner_idx = '0;
        any_valid  = 1'b0;
        idx        = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDW'((32'(ptr) + k) % N);
            if (!any_valid && req_valid[idx]) begin
                any_valid      = 1'b1;
                winner_idx     = idx;
                winner_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
// Round-robin arbiter/sequencer sharing one 8x8 multiplier between NUM_REQ
// requesters. Accepts one operand pair, holds it on the multiplier inputs,
// pulses mul_start, waits for mul_done (or TIMEOUT WAIT cycles) and returns
// the product to the granted requester as a one-cycle rsp_valid pulse.
// Ports:
//   clk, aclr_n             clock (rising edge), async active-low reset
//   req_valid/req_dataa/b   per-requester request and operands (8 bits each,
//                           requester i at [8i+7:8i])
//   req_ready               one-hot accept, only while IDLE
//   rsp_valid/product/error one-hot response pulse, product, timeout flag
//   mul_dataa/b, mul_start  multiplier operands (held ISSUE..RESP) and start
//   mul_done, mul_product   multiplier done flag and result
//   busy                    high whenever not IDLE
// Optional: define MULT_ARB_ZERO_BYPASS_EN to answer zero-operand requests
// directly from IDLE (product 0, no mul_start).
// -----------------------------------------------------------------------------
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [OPW*NUM_REQ-1:0] req_dataa,
    input  logic [OPW*NUM_REQ-1:0] req_datab,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [PRODW-1:0]       rsp_product,
    output logic                   rsp_error,
    output logic [OPW-1:0]         mul_dataa,
    output logic [OPW-1:0]         mul_datab,
    output logic                   mul_start,
    input  logic                   mul_done,
    input  logic [PRODW-1:0]       mul_product,
    output logic                   busy
);

    localparam int unsigned IDW = $clog2(NUM_REQ);

    state_t             state;
    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     grant_id;
    logic [7:0]         cnt;

    logic [NUM_REQ-1:0] winner_oh;
    logic [IDW-1:0]     win_idx;
    logic               any_valid;
    logic [OPW-1:0]     win_a;
    logic [OPW-1:0]     win_b;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDW-1:0]     ptr_next;
    logic               zero_op;

    rr_picker #(
        .N   (NUM_REQ),
        .IDW (IDW)
    ) u_picker (
        .req_valid  (req_valid),
        .ptr        (ptr),
        .winner_oh  (winner_oh),
        .winner_idx (win_idx),
        .any_valid  (any_valid)
    );

    // Operand mux driven by the one-hot winner.
    always_comb begin
        win_a = '0;
        win_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            win_a = win_a | (req_dataa[i*OPW +: OPW] & {OPW{winner_oh[i]}});
            win_b = win_b | (req_datab[i*OPW +: OPW] & {OPW{winner_oh[i]}});
        end
    end

    always_comb begin
        grant_oh = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            grant_oh[i] = (grant_id == IDW'(i));
        end
    end

    assign ptr_next = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef MULT_ARB_ZERO_BYPASS_EN
    assign zero_op = zero_operand(win_a, win_b);
`else
    assign zero_op = 1'b0;
`endif

    // Accept is combinational; gating with aclr_n keeps it low during reset.
    assign req_ready = (aclr_n && (state == IDLE)) ? winner_oh : '0;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state       <= IDLE;
            ptr         <= '0;
            grant_id    <= '0;
            cnt         <= '0;
            rsp_valid   <= '0;
            rsp_product <= '0;
            rsp_error   <= 1'b0;
            mul_dataa   <= '0;
            mul_datab   <= '0;
            mul_start   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            mul_start <= 1'b0;
            rsp_valid <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        mul_dataa <= win_a;
                        mul_datab <= win_b;
                        grant_id  <= win_idx;
                        ptr       <= ptr_next;
                        busy      <= 1'b1;
                        if (zero_op) begin
                            state       <= RESP;
                            rsp_valid   <= winner_oh;
                            rsp_product <= '0;
                            rsp_error   <= 1'b0;
                        end else begin
                            state     <= ISSUE;
                            mul_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    state <= WAIT;
                    cnt   <= '0;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // cnt==0 is the first WAIT cycle; a done there is stale.
                    // Done is tested before timeout so a tie is a success.
                    if (mul_done && (cnt != '0)) begin
                        state       <= RESP;
                        rsp_valid   <= grant_oh;
                        rsp_product <= mul_product;
                        rsp_error   <= 1'b0;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        state       <= RESP;
                        rsp_valid   <= grant_oh;
                        rsp_product <= '0;
                        rsp_error   <= 1'b1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_arbiter.sv
module tb_mult_arbiter;

    localparam int NREQ = 4;
    localparam int TMO  = 15;

    logic              clk = 1'b0;
    logic              aclr_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_dataa;
    logic [8*NREQ-1:0] req_datab;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [15:0]       rsp_product;
    logic              rsp_error;
    logic [7:0]        mul_dataa;
    logic [7:0]        mul_datab;
    logic              mul_start;
    logic              mul_done;
    logic [15:0]       mul_product;
    logic              busy;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mult_arbiter #(
        .NUM_REQ (NREQ),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .aclr_n      (aclr_n),
        .req_valid   (req_valid),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_product (rsp_product),
        .rsp_error   (rsp_error),
        .mul_dataa   (mul_dataa),
        .mul_datab   (mul_datab),
        .mul_start   (mul_start),
        .mul_done    (mul_done),
        .mul_product (mul_product),
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- multiplier model ----------------
    // mode 0: done goes (and stays) high dly cycles after start; 1: never; 2: always high
    int cyc = 0;
    int start_cyc = -1000;
    int mode = 0;
    int dly = 4;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mul_start) start_cyc <= cyc;
    end
    assign mul_done    = (mode == 2) || (mode == 0 && (cyc - start_cyc) >= dly);
    assign mul_product = 16'(mul_dataa) * 16'(mul_datab);

    // done as seen in the k-th WAIT cycle after start
    function automatic bit done_at(input int k);
        return (mode == 2) || (mode == 0 && k >= dly);
    endfunction

    function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // ---------------- reference model + per-cycle compare ----------------
    int          mn = 0;       // period index
    bit          job = 0;
    int          j_acc = 0, j_rsp = 0, j_req = 0;
    bit          j_byp = 0, j_err = 0;
    logic [15:0] j_prod = '0;
    int          m_ptr = 0;
    logic [15:0] m_prod = '0;
    logic [7:0]  m_a = '0, m_b = '0;
    logic [NREQ-1:0] hs_q = '0;

    always @(negedge clk) begin
        int w;
        bit active;
        logic [NREQ-1:0] exp_rv, exp_rdy;
        hs_q = req_valid & req_ready;
        if (!aclr_n) begin
            job = 0; m_ptr = 0; m_prod = '0; m_a = '0; m_b = '0;
            chk("reset_outputs", 64'({req_ready, rsp_valid, rsp_product, rsp_error,
                                      mul_dataa, mul_datab, mul_start, busy}), 64'd0);
        end else begin
            active = job && (mn > j_acc) && (mn <= j_rsp);
            exp_rv = '0;
            if (job && mn == j_rsp) begin
                m_prod = j_prod;
                exp_rv[j_req] = 1'b1;
            end
            exp_rdy = '0;
            w = active ? -1 : rr_pick(req_valid, m_ptr);
            if (w >= 0) exp_rdy[w] = 1'b1;
            chk("busy", 64'(busy), 64'(active));
            chk("mul_start", 64'(mul_start), 64'(active && !j_byp && mn == j_acc + 1));
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            chk("rsp_product", 64'(rsp_product), 64'(m_prod));
            if (exp_rv != '0) chk("rsp_error", 64'(rsp_error), 64'(j_err));
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            chk("mul_operands", 64'({mul_dataa, mul_datab}), 64'({m_a, m_b}));
            if (w >= 0) begin
                job   = 1;
                j_acc = mn;
                j_req = w;
                m_a   = req_dataa[8*w +: 8];
                m_b   = req_datab[8*w +: 8];
                m_ptr = (w + 1) % NREQ;
                j_prod = 16'(m_a) * 16'(m_b);
`ifdef MULT_ARB_ZERO_BYPASS_EN
                j_byp = (m_a == 8'd0) || (m_b == 8'd0);
`else
                j_byp = 0;
`endif
                if (j_byp) begin
                    j_prod = '0; j_err = 0; j_rsp = mn + 1;
                end else begin
                    j_err = 1; j_rsp = mn + 1 + TMO + 1;
                    for (int k = 2; k <= TMO; k++) begin
                        if (done_at(k)) begin
                            j_err = 0; j_rsp = mn + 1 + k + 1;
                            break;
                        end
                    end
                    if (j_err) j_prod = '0;
                end
            end
        end
        mn++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b);
        req_valid[r]         = 1'b1;
        req_dataa[8*r +: 8]  = a;
        req_datab[8*r +: 8]  = b;
    endtask

    function automatic logic [7:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 8'd0;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    task automatic single(input int r, input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] p, output logic e);
        int t;
        t = 0;
        @(posedge clk); #1;
        set_req(r, a, b);
        @(negedge clk);
        while (!req_ready[r] && t < 50) begin @(negedge clk); t++; end
        chk("accept_bound", 64'(t < 50), 64'd1);
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[r] && lat < 60) begin @(negedge clk); lat++; end
        chk("response_bound", 64'(lat < 60), 64'd1);
        p = rsp_product;
        e = rsp_error;
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1;
        aclr_n = 1'b0;
        #1;
        chk("reset_immediate", 64'({req_ready, rsp_valid, rsp_product, rsp_error,
                                    mul_dataa, mul_datab, mul_start, busy}), 64'd0);
        repeat (2) @(posedge clk);
        #1 aclr_n = 1'b1;
    endtask

    task automatic quiesce();
        int t;
        t = 0;
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        while (busy && t < 40) begin @(negedge clk); t++; end
        chk("quiesce_bound", 64'(t < 40), 64'd1);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat, t, nr;
        logic [15:0] p;
        logic e;
        int order[5];
        logic [15:0] prods[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};

        aclr_n = 1'b0; req_valid = '0; req_dataa = '0; req_datab = '0;
        repeat (3) @(posedge clk);
        #1 aclr_n = 1'b1;

        // single request, done 4 WAIT cycles after start
        mode = 0; dly = 4;
        single(0, 8'd13, 8'd11, lat, p, e);
        chk("single_product", 64'(p), 64'd143);
        chk("single_error", 64'(e), 64'd0);
        chk("single_latency", 64'(lat), 64'd6);

        // fairness from ptr=0
        reset_pulse();
        @(posedge clk); #1;
        set_req(0, 8'd1, 8'd2); set_req(1, 8'd3, 8'd4);
        set_req(2, 8'd10, 8'd20); set_req(3, 8'hFF, 8'hFF);
        nr = 0; t = 0;
        while (nr < 5 && t < 200) begin
            @(negedge clk); t++;
            if (rsp_valid != '0) begin
                order[nr] = -1;
                for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) order[nr] = i;
                prods[nr] = rsp_product;
                nr++;
            end
        end
        chk("fair_bound", 64'(nr), 64'd5);
        for (int i = 0; i < 5; i++) chk("fair_order", 64'(order[i]), 64'(exp_order[i]));
        chk("fair_prod_req3", 64'(prods[3]), 64'hFE01);
        chk("fair_prod_req2", 64'(prods[2]), 64'd200);
        quiesce();

        // timeout, then normal service
        mode = 1;
        single(1, 8'd5, 8'd6, lat, p, e);
        chk("timeout_latency", 64'(lat), 64'd17);
        chk("timeout_error", 64'(e), 64'd1);
        chk("timeout_product", 64'(p), 64'd0);
        mode = 0; dly = 3;
        single(1, 8'd5, 8'd6, lat, p, e);
        chk("after_timeout_product", 64'(p), 64'd30);
        chk("after_timeout_error", 64'(e), 64'd0);

        // stale done held high
        mode = 2;
        single(0, 8'd9, 8'd9, lat, p, e);
        chk("stale_latency", 64'(lat), 64'd4);
        chk("stale_product", 64'(p), 64'd81);

        // reset in the middle of WAIT
        mode = 1;
        @(posedge clk); #1;
        set_req(1, 8'd7, 8'd7);
        t = 0;
        @(negedge clk);
        while (!req_ready[1] && t < 50) begin @(negedge clk); t++; end
        chk("midwait_accept_bound", 64'(t < 50), 64'd1);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(2, 8'd4, 8'd5);
        repeat (3) @(posedge clk);
        #1 aclr_n = 1'b0;
        #1 chk("midwait_reset_outputs", 64'({req_ready, rsp_valid, rsp_product, rsp_error,
                                            mul_dataa, mul_datab, mul_start, busy}), 64'd0);
        repeat (2) @(posedge clk);
        #1 aclr_n = 1'b1;
        @(negedge clk);
        chk("post_reset_grant", 64'(req_ready), 64'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rsp_valid[2] && lat < 60) begin @(negedge clk); lat++; end
        chk("post_reset_rsp_latency", 64'(lat), 64'd17);
        mode = 0; dly = 4;

        // zero operand
        single(3, 8'd0, 8'd77, lat, p, e);
        chk("zero_product", 64'(p), 64'd0);
        chk("zero_error", 64'(e), 64'd0);
`ifdef MULT_ARB_ZERO_BYPASS_EN
        chk("zero_latency", 64'(lat), 64'd1);
`else
        chk("zero_latency", 64'(lat), 64'd6);
`endif

        // randomized phases
        for (int ph = 0; ph < 8; ph++) begin
            int sel;
            sel  = int'($urandom_range(0, 9));
            mode = (sel < 7) ? 0 : ((sel == 7) ? 1 : 2);
            dly  = int'($urandom_range(1, 7));
            for (int c = 0; c < 300; c++) begin
                @(posedge clk); #1;
                for (int i = 0; i < NREQ; i++) begin
                    if (req_valid[i] && hs_q[i]) begin
                        if ($urandom_range(0, 1) == 1) set_req(i, rand_op(), rand_op());
                        else req_valid[i] = 1'b0;
                    end else if (!req_valid[i]) begin
                        if ($urandom_range(0, 3) == 0) set_req(i, rand_op(), rand_op());
                    end else if ($urandom_range(0, 99) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
            quiesce();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_time_limit: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
